// File: rtl/int_sequencer.sv
// int_sequencer: core-side interrupt entry/return sequencer with a 4-word register window
module int_sequencer #(
  parameter int VEC_SHIFT = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [1:0]  i_memAddr,
  input  logic [15:0] i_memDataIn,
  input  logic        i_memWrEn,
  output logic [15:0] o_memDataOut,
  input  logic [3:0]  i_intCode,
  input  logic        i_intEn,
  input  logic        i_pipeEmpty,
  input  logic [15:0] i_resumePC,
  input  logic        i_rtiEn,
  output logic        o_stall,
  output logic        o_jmpEn,
  output logic [15:0] o_jmpAddr,
  output logic        o_ackEn,
  output logic [3:0]  o_ackCode
);
  typedef enum logic [1:0] {IDLE, DRAIN, VECTOR, RETURN} state_t;
  state_t      state_q, state_d;
  logic        gie_q, gie_d, pgie_q, pgie_d;
  logic [15:0] epc_q, epc_d, vbase_q, vbase_d;
  logic [3:0]  code_q, code_d;
  logic        stall_q, stall_d, jmp_en_q, jmp_en_d, ack_en_q, ack_en_d;
  logic [15:0] jmp_addr_q, jmp_addr_d;
  logic [3:0]  ack_code_q, ack_code_d;
  logic        wr_ctrl, wr_epc, wr_vbase;
  assign wr_ctrl  = i_memWrEn && i_memAddr == 2'd0;
  assign wr_epc   = i_memWrEn && i_memAddr == 2'd1;
  assign wr_vbase = i_memWrEn && i_memAddr == 2'd3;
  assign o_memDataOut = i_memAddr == 2'd0 ? {14'b0, pgie_q, gie_q} :
                        i_memAddr == 2'd1 ? epc_q :
                        i_memAddr == 2'd2 ? {12'b0, code_q} : vbase_q;
  assign o_stall   = stall_q;
  assign o_jmpEn   = jmp_en_q;
  assign o_jmpAddr = jmp_addr_q;
  assign o_ackEn   = ack_en_q;
  assign o_ackCode = ack_code_q;
  // next state, register updates (hardware overrides software) and next-cycle outputs
  always_comb begin
    state_d = state_q;
    gie_d   = wr_ctrl ? i_memDataIn[0] : gie_q;
    pgie_d  = wr_ctrl ? i_memDataIn[1] : pgie_q;
    epc_d   = wr_epc ? i_memDataIn : epc_q;
    vbase_d = wr_vbase ? i_memDataIn : vbase_q;
    code_d  = code_q;
    case (state_q)
      IDLE:    state_d = i_rtiEn ? RETURN : (gie_q && i_intEn) ? DRAIN : IDLE;
      DRAIN: begin
        if (!i_intEn) state_d = IDLE;
        else if (i_pipeEmpty) begin
          epc_d   = i_resumePC;
          code_d  = i_intCode;
          state_d = VECTOR;
        end
      end
      VECTOR: begin
        pgie_d  = gie_q;
        gie_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gie_d   = pgie_q;
        pgie_d  = pgie_q;
        state_d = IDLE;
      end
    endcase
    stall_d    = state_d != IDLE;
    jmp_en_d   = state_d == VECTOR || state_d == RETURN;
    ack_en_d   = state_d == VECTOR;
    ack_code_d = state_d == VECTOR ? code_d : 4'd0;
    jmp_addr_d = state_d == VECTOR ? vbase_d + (16'(code_d) << VEC_SHIFT) :
                 state_d == RETURN ? epc_d : 16'd0;
  end
  // state, registers and registered outputs; async reset aborts any sequence
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      gie_q      <= 1'b0;
      pgie_q     <= 1'b0;
      epc_q      <= 16'd0;
      vbase_q    <= 16'd0;
      code_q     <= 4'd0;
      stall_q    <= 1'b0;
      jmp_en_q   <= 1'b0;
      jmp_addr_q <= 16'd0;
      ack_en_q   <= 1'b0;
      ack_code_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      gie_q      <= gie_d;
      pgie_q     <= pgie_d;
      epc_q      <= epc_d;
      vbase_q    <= vbase_d;
      code_q     <= code_d;
      stall_q    <= stall_d;
      jmp_en_q   <= jmp_en_d;
      jmp_addr_q <= jmp_addr_d;
      ack_en_q   <= ack_en_d;
      ack_code_q <= ack_code_d;
    end
  end
endmodule
